// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: freezes fetch and bubbles ID/EX on load-use hazards
// and on HI/LO or multiplier accesses while the multiply unit is still busy.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [31:0]          instruction,
  input  logic [31:0]          programCounterOut,
  input  logic                 flush,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 idExBubble,
  output logic [31:0]          stallPc,
  output logic [CNT_WIDTH-1:0] stallCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  localparam logic [3:0] MULT_RELOAD = 4'(MULT_CYCLES - 1);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  logic       readsRs;
  logic       readsRt;
  logic       isRType;
  logic       isMult;
  logic       isMultUser;
  logic       loadHaz;
  logic       multHaz;
  logic       stall;

  logic       exLoadValid;
  logic [4:0] exLoadRt;
  logic [3:0] multBusy;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign funct = instruction[5:0];

  always_comb begin
    readsRs    = (op != OP_J) && (op != OP_JAL);
    readsRt    = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    isRType    = (op == OP_RTYPE);
    isMult     = isRType && ((funct == FN_MULT) || (funct == FN_MULTU));
    isMultUser = isRType && ((funct == FN_MFHI) || (funct == FN_MFLO) ||
                             (funct == FN_MULT) || (funct == FN_MULTU));
  end

  // Register 0 is hard-wired, so a load targeting it can never create a dependency.
  always_comb begin
    loadHaz = exLoadValid && (exLoadRt != '0) &&
              ((readsRs && (rs == exLoadRt)) || (readsRt && (rt == exLoadRt)));
    multHaz = (multBusy != '0) && isMultUser;
    stall   = (loadHaz || multHaz) && !flush;
  end

  always_comb begin
    pcWrite    = !stall;
    ifIdWrite  = !stall;
    idExBubble = stall || flush;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      exLoadValid <= 1'b0;
      exLoadRt    <= '0;
    end else begin
      exLoadValid <= (op == OP_LW) && !idExBubble;
      exLoadRt    <= rt;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      multBusy <= '0;
    end else if (isMult && !idExBubble) begin
      multBusy <= MULT_RELOAD;
    end else if (multBusy != '0) begin
      multBusy <= multBusy - 4'd1;
    end
  end

  // Counter sticks at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stallPc    <= '0;
      stallCount <= '0;
    end else if (stall) begin
      stallPc <= programCounterOut;
      if (stallCount != '1) begin
        stallCount <= stallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomised and directed checks of hazard_stall_unit against a cycle-indexed reference model.
module tb_hazard_stall_unit;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] instruction;
  logic [31:0] programCounterOut;
  logic        flush;

  logic        pcWrite, ifIdWrite, idExBubble;
  logic [31:0] stallPc;
  logic [15:0] stallCount;

  logic        pcWriteS, ifIdWriteS, idExBubbleS;
  logic [31:0] stallPcS;
  logic [2:0]  stallCountS;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          cyc;
  bit          prevLw;
  logic [4:0]  prevRt;
  int          lastMult;
  int          expCount;
  logic [31:0] expPc;
  bit          expStall;
  bit          expBubble;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULT_CYCLES(MC), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstN(rstN), .instruction(instruction),
    .programCounterOut(programCounterOut), .flush(flush),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExBubble(idExBubble),
    .stallPc(stallPc), .stallCount(stallCount)
  );

  hazard_stall_unit #(.MULT_CYCLES(MC), .CNT_WIDTH(3)) dutSmall (
    .clk(clk), .rstN(rstN), .instruction(instruction),
    .programCounterOut(programCounterOut), .flush(flush),
    .pcWrite(pcWriteS), .ifIdWrite(ifIdWriteS), .idExBubble(idExBubbleS),
    .stallPc(stallPcS), .stallCount(stallCountS)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0010};
  endfunction

  function automatic bit readsReg(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op;
    bit rsRead, rtRead;
    op = ins[31:26];
    if (r == 5'd0) return 1'b0;
    rsRead = !(op == 6'd2 || op == 6'd3);
    rtRead = (op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'h2b);
    return (rsRead && ins[25:21] == r) || (rtRead && ins[20:16] == r);
  endfunction

  function automatic bit usesMult(input logic [31:0] ins);
    logic [5:0] fn;
    fn = ins[5:0];
    return ins[31:26] == 6'd0 && (fn == 6'h10 || fn == 6'h12 || fn == 6'h18 || fn == 6'h19);
  endfunction

  task automatic modelReset();
    prevLw   = 1'b0;
    prevRt   = '0;
    lastMult = -1000;
    expCount = 0;
    expPc    = '0;
  endtask

  task automatic modelEval(input logic [31:0] ins, input bit fl);
    bit loadHaz, busy, multHaz;
    loadHaz   = prevLw && readsReg(ins, prevRt);
    busy      = (cyc - lastMult >= 1) && (cyc - lastMult <= MC - 1);
    multHaz   = busy && usesMult(ins);
    expStall  = (loadHaz || multHaz) && !fl;
    expBubble = expStall || fl;
  endtask

  task automatic checkCounters();
    checkEq("stallCount", {16'd0, stallCount}, expCount);
    checkEq("stallPc", stallPc, expPc);
    checkEq("stallCountSat", {29'd0, stallCountS}, (expCount > 7) ? 7 : expCount);
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input bit fl);
    bit isMultIns;
    instruction = ins;
    programCounterOut = pc;
    flush = fl;
    #1;
    modelEval(ins, fl);
    checkEq("pcWrite", {31'd0, pcWrite}, {31'd0, !expStall});
    checkEq("ifIdWrite", {31'd0, ifIdWrite}, {31'd0, !expStall});
    checkEq("idExBubble", {31'd0, idExBubble}, {31'd0, expBubble});
    checkEq("smallBubble", {31'd0, idExBubbleS}, {31'd0, expBubble});
    @(posedge clk);
    #1;
    isMultIns = usesMult(ins) && (ins[5:0] == 6'h18 || ins[5:0] == 6'h19);
    prevLw = (ins[31:26] == 6'h23) && !expBubble;
    prevRt = ins[20:16];
    if (isMultIns && !expBubble) lastMult = cyc;
    if (expStall) begin
      expCount++;
      expPc = pc;
    end
    cyc++;
    checkCounters();
  endtask

  function automatic logic [31:0] randInstr();
    int a, b, c;
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    case ($urandom_range(0, 10))
      0, 1: return iType(6'h23, a, b);
      2:    return rType(a, b, c, 6'h20);
      3:    return rType(a, b, 0, 6'h18);
      4:    return rType(a, b, 0, 6'h19);
      5:    return rType(0, 0, c, 6'h12);
      6:    return rType(0, 0, c, 6'h10);
      7:    return iType(6'h2b, a, b);
      8:    return iType(6'h04, a, b);
      9:    return {6'h02, 26'(b * 5 + a)};
      default: return iType(6'h08, a, b);
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    cyc = 0;
    modelReset();
    rstN = 1'b0;
    instruction = '0;
    programCounterOut = '0;
    flush = 1'b0;
    #12;
    checkEq("rstPcWrite", {31'd0, pcWrite}, 32'd1);
    checkEq("rstBubble", {31'd0, idExBubble}, 32'd0);
    checkCounters();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // load-use: exactly one stall with the add's PC recorded
    step(iType(6'h23, 1, 8), 32'h100, 1'b0);
    step(rType(8, 2, 9, 6'h20), 32'h104, 1'b0);
    checkEq("luStallPc", stallPc, 32'h104);
    checkEq("luCount", {16'd0, stallCount}, 32'd1);
    step(rType(8, 2, 9, 6'h20), 32'h104, 1'b0);
    checkEq("luResume", {31'd0, pcWrite}, 32'd1);

    // $0 destination and independent consumer
    step(iType(6'h23, 1, 0), 32'h108, 1'b0);
    step(rType(0, 2, 9, 6'h20), 32'h10c, 1'b0);
    step(iType(6'h23, 1, 8), 32'h110, 1'b0);
    step(rType(3, 4, 9, 6'h20), 32'h114, 1'b0);
    checkEq("noStallCount", {16'd0, stallCount}, 32'd1);

    // mult then mflo: MULT_CYCLES-1 stalls
    step(rType(1, 2, 0, 6'h18), 32'h118, 1'b0);
    for (int i = 0; i < 4; i++) step(rType(0, 0, 3, 6'h12), 32'h11c, 1'b0);
    checkEq("multCount", {16'd0, stallCount}, 32'd4);

    // independent add right after mult
    step(rType(1, 2, 0, 6'h19), 32'h120, 1'b0);
    step(rType(5, 6, 7, 6'h20), 32'h124, 1'b0);
    checkEq("multIndep", {16'd0, stallCount}, 32'd4);
    for (int i = 0; i < 3; i++) step(32'h0, 32'h128, 1'b0);

    // flush overrides a load-use hazard
    step(iType(6'h23, 1, 8), 32'h200, 1'b0);
    step(rType(8, 2, 9, 6'h20), 32'h204, 1'b1);
    checkEq("flushCount", {16'd0, stallCount}, 32'd4);

    // asynchronous reset mid-stall (multBusy=2)
    step(rType(1, 2, 0, 6'h18), 32'h300, 1'b0);
    step(rType(0, 0, 3, 6'h12), 32'h304, 1'b0);
    instruction = rType(0, 0, 3, 6'h12);
    #1;
    checkEq("preRstStall", {31'd0, pcWrite}, 32'd0);
    rstN = 1'b0;
    #1;
    checkEq("asyncPcWrite", {31'd0, pcWrite}, 32'd1);
    checkEq("asyncIfIdWrite", {31'd0, ifIdWrite}, 32'd1);
    checkEq("asyncBubble", {31'd0, idExBubble}, 32'd0);
    checkEq("asyncCount", {16'd0, stallCount}, 32'd0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // randomised traffic
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step(randInstr(), pc, ($urandom_range(0, 9) == 0));
      pc = pc + 4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
